// File: rtl/arr_pkg.sv
// arr_pkg: shared state type, address-width helper and read latency for the array memory arbiter
package arr_pkg;
  typedef enum logic {S_CLEAR, S_SERVE} arr_state_t;
  localparam int RSP_LAT = 1;
  function automatic int arr_clog2(input int n);
    int w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/arr_rr_arbiter.sv
// arr_rr_arbiter: rotating-priority one-hot grant; pointer moves past each granted channel
module arr_rr_arbiter import arr_pkg::*; #(
  parameter int NCH = 2,
  localparam int PW = arr_clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] grant,
  output logic [PW-1:0]  ptr
);
  logic [PW-1:0] j, hit, ptr_nx;
  // first requesting channel searching upward from ptr, wrapping at NCH
  always_comb begin
    grant = '0;
    hit = '0;
    j = '0;
    for (int i = 0; i < NCH; i++) begin
      j = PW'((32'(ptr) + 32'(i)) % NCH);
      if (en && grant == '0 && req[j]) begin
        grant[j] = 1'b1;
        hit = j;
      end
    end
    ptr_nx = (32'(hit) == NCH - 1) ? '0 : hit + 1'b1;
  end
  // a grant is always a handshake since only valid channels are granted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (|grant) ptr <= ptr_nx;
endmodule

// File: rtl/arr_mem_arbiter.sv
// arr_mem_arbiter: single-port RAM shared by NCH round-robin channels with a host override port
// ARR_CLEAR_EN: when defined, reset zero-fills the array (busy=1) before serving
module arr_mem_arbiter import arr_pkg::*; #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 2,
  parameter int NCH = 2,
  localparam int AW = arr_clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_en,
  input  logic                  ctrl_wen,
  input  logic [AW-1:0]         ctrl_addr,
  input  logic [DATA_W-1:0]     ctrl_wdata,
  output logic                  ctrl_rvalid,
  output logic [DATA_W-1:0]     ctrl_rdata,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH-1:0]        req_wen,
  input  logic [NCH*AW-1:0]     req_addr,
  input  logic [NCH*DATA_W-1:0] req_wdata,
  output logic [NCH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  busy
);
  localparam int PW = arr_clog2(NCH);
`ifdef ARR_CLEAR_EN
  localparam arr_state_t RST_STATE = S_CLEAR;
`else
  localparam arr_state_t RST_STATE = S_SERVE;
`endif
  arr_state_t state, state_nx;
  logic [AW-1:0] clr_addr, addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wdata, rd;
  logic we, host_rd, in_range;
  logic [NCH-1:0] grant, ch_rd;
  logic [PW-1:0] ptr;
  arr_rr_arbiter #(.NCH(NCH)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .en(rst_n && !ctrl_en && !busy),
    .req(req_valid),
    .grant(grant),
    .ptr(ptr)
  );
  assign req_ready = grant;
  assign busy = (state == S_CLEAR);
  assign ch_rd = grant & ~req_wen;
  assign host_rd = ctrl_en && !busy && !ctrl_wen;
  assign in_range = 32'(addr) < DEPTH;
  assign rd = in_range ? mem[addr] : '0;
  // rotation pointer never leaves the channel range
  ptr_in_range: assert property (@(posedge clk) disable iff (!rst_n) 32'(ptr) < NCH);
  // clear leaves S_CLEAR after the last address is written
  always_comb state_nx = (state == S_CLEAR && 32'(clr_addr) == DEPTH - 1) ? S_SERVE : state;
  // state register and clear address walker
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RST_STATE;
      clr_addr <= '0;
    end else begin
      state <= state_nx;
      clr_addr <= busy ? clr_addr + 1'b1 : clr_addr;
    end
  // single access per cycle: clear beats host, host beats the granted channel
  always_comb begin
    we = 1'b0;
    addr = '0;
    wdata = '0;
    for (int k = 0; k < NCH; k++)
      if (grant[k]) begin
        we = req_wen[k];
        addr = req_addr[k*AW +: AW];
        wdata = req_wdata[k*DATA_W +: DATA_W];
      end
    if (ctrl_en) begin
      we = ctrl_wen;
      addr = ctrl_addr;
      wdata = ctrl_wdata;
    end
    if (busy) begin
      we = 1'b1;
      addr = clr_addr;
      wdata = '0;
    end
  end
  // storage is not reset; writes beyond DEPTH are dropped
  always_ff @(posedge clk)
    if (rst_n && we && in_range) mem[addr] <= wdata;
  // registered read responses; data holds between valid pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data <= '0;
      ctrl_rvalid <= 1'b0;
      ctrl_rdata <= '0;
    end else begin
      rsp_valid <= ch_rd;
      ctrl_rvalid <= host_rd;
      if (|ch_rd) rsp_data <= rd;
      if (host_rd) ctrl_rdata <= rd;
    end
endmodule

// File: tb/tb_arr_mem_arbiter.sv
// tb_arr_mem_arbiter: scoreboard bench for arr_mem_arbiter (DEPTH=3, NCH=3)
module tb_arr_mem_arbiter;
  localparam int DW = 64, DEPTH = 3, NCH = 3, AW = 2;
`ifdef ARR_CLEAR_EN
  localparam int CLR = DEPTH;
  localparam int P0 = 1;
`else
  localparam int CLR = 0;
  localparam int P0 = 0;
`endif
  typedef struct {int due; logic [NCH-1:0] vld; logic [DW-1:0] data;} exp_t;
  logic clk = 1'b0, rst_n = 1'b0, ctrl_en = 1'b0, ctrl_wen = 1'b0;
  logic [AW-1:0] ctrl_addr = '0;
  logic [DW-1:0] ctrl_wdata = '0;
  logic [NCH-1:0] req_valid = '0, req_wen = '0;
  logic [NCH*AW-1:0] req_addr = '0;
  logic [NCH*DW-1:0] req_wdata = '0;
  logic ctrl_rvalid, busy;
  logic [DW-1:0] ctrl_rdata, rsp_data;
  logic [NCH-1:0] req_ready, rsp_valid;
  logic [DW-1:0] mm [DEPTH];
  exp_t rq[$], cq[$], e;
  int cyc = 0, n_chk = 0, n_err = 0;

  arr_mem_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_en(ctrl_en), .ctrl_wen(ctrl_wen), .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
    .ctrl_rvalid(ctrl_rvalid), .ctrl_rdata(ctrl_rdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n) begin
      while (rq.size() != 0 && rq[0].due < cyc) begin
        e = rq.pop_front();
        n_chk++; n_err++;
        $display("FAIL rsp_missing due=%0d want valid=%b data=%h", e.due, e.vld, e.data);
      end
      while (cq.size() != 0 && cq[0].due < cyc) begin
        e = cq.pop_front();
        n_chk++; n_err++;
        $display("FAIL ctrl_missing due=%0d want data=%h", e.due, e.data);
      end
      n_chk++;
      if (rq.size() != 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        if (rsp_valid !== e.vld || rsp_data !== e.data) begin
          n_err++;
          $display("FAIL rsp got valid=%b data=%h want valid=%b data=%h", rsp_valid, rsp_data, e.vld, e.data);
        end
      end else if (rsp_valid !== '0) begin
        n_err++;
        $display("FAIL rsp_unexpected got valid=%b want 000", rsp_valid);
      end
      n_chk++;
      if (cq.size() != 0 && cq[0].due == cyc) begin
        e = cq.pop_front();
        if (ctrl_rvalid !== 1'b1 || ctrl_rdata !== e.data) begin
          n_err++;
          $display("FAIL ctrl_rsp got rvalid=%b data=%h want rvalid=1 data=%h", ctrl_rvalid, ctrl_rdata, e.data);
        end
      end else if (ctrl_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL ctrl_unexpected got rvalid=%b want 0", ctrl_rvalid);
      end
    end
  end

  task automatic set_ch(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k] = 1'b1;
    req_wen[k] = w;
    req_addr[k*AW +: AW] = a;
    req_wdata[k*DW +: DW] = d;
  endtask

  task automatic issue(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_ch(k, w, a, d);
    if (w) begin
      if (int'(a) < DEPTH) mm[a] = d;
    end else rq.push_back('{cyc + 1, NCH'(1 << k), (int'(a) < DEPTH) ? mm[a] : '0});
  endtask

  task automatic host(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ctrl_en = 1'b1;
    ctrl_wen = w;
    ctrl_addr = a;
    ctrl_wdata = d;
    if (w) begin
      if (int'(a) < DEPTH) mm[a] = d;
    end else cq.push_back('{cyc + 1, '0, (int'(a) < DEPTH) ? mm[a] : '0});
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    for (int k = 0; k < NCH; k++) set_ch(k, 1'b0, AW'(k), '0);
    repeat (2) @(negedge clk);
    n_chk++;
    if ({req_ready, rsp_valid, ctrl_rvalid, busy} !== {3'b000, 3'b000, 1'b0, CLR != 0} || rsp_data !== '0 || ctrl_rdata !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got ready=%b rsp_valid=%b rvalid=%b busy=%b rsp_data=%h rdata=%h", req_ready, rsp_valid, ctrl_rvalid, busy, rsp_data, ctrl_rdata);
    end
    req_valid = '0;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      n++;
      @(negedge clk);
    end
    n_chk++;
    if (n != CLR) begin
      n_err++;
      $display("FAIL busy_cycles got %0d want %0d", n, CLR);
    end
`ifdef ARR_CLEAR_EN
    for (int a = 0; a < DEPTH; a++) mm[a] = '0;
    for (int a = 0; a < DEPTH; a++) begin
      req_valid = '0;
      issue(0, 1'b0, AW'(a), '0);
      #1;
      n_chk++;
      if (req_ready !== 3'b001) begin
        n_err++;
        $display("FAIL clear_read_ready addr=%0d got %b want 001", a, req_ready);
      end
      @(negedge clk);
    end
    req_valid = '0;
`endif
  endtask

  task automatic test_ctrl();
    for (int k = 0; k < NCH; k++) set_ch(k, 1'b0, '0, '0);
    host(1'b1, 2'd1, -64'sd3);
    #1;
    n_chk++;
    if (req_ready !== 3'b000) begin
      n_err++;
      $display("FAIL ctrl_wr_ready got %b want 000", req_ready);
    end
    @(negedge clk);
    host(1'b0, 2'd1, '0);
    #1;
    n_chk++;
    if (req_ready !== 3'b000) begin
      n_err++;
      $display("FAIL ctrl_rd_ready got %b want 000", req_ready);
    end
    @(negedge clk);
    ctrl_en = 1'b0;
    req_valid = '0;
    n_chk++;
    if (ctrl_rvalid !== 1'b1 || ctrl_rdata !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_err++;
      $display("FAIL ctrl_rdata got rvalid=%b data=%h want 1 FFFFFFFFFFFFFFFD", ctrl_rvalid, ctrl_rdata);
    end
    @(negedge clk);
    n_chk++;
    if (ctrl_rvalid !== 1'b0 || ctrl_rdata !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_err++;
      $display("FAIL ctrl_hold got rvalid=%b data=%h want 0 FFFFFFFFFFFFFFFD", ctrl_rvalid, ctrl_rdata);
    end
  endtask

  task automatic test_rr();
    logic [NCH-1:0] want;
    int g;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NCH; k++) set_ch(k, i < 3, AW'(k), DW'(100 + k));
      g = (P0 + i) % NCH;
      want = NCH'(1 << g);
      #1;
      n_chk++;
      if (req_ready !== want) begin
        n_err++;
        $display("FAIL rr_grant step=%0d got %b want %b", i, req_ready, want);
      end
      if (i < 3) mm[g] = DW'(100 + g);
      else rq.push_back('{cyc + 1, want, mm[g]});
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    issue(1, 1'b1, 2'd0, 64'd7);
    #1;
    n_chk++;
    if (req_ready !== 3'b010) begin
      n_err++;
      $display("FAIL b2b_wr_ready got %b want 010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    issue(0, 1'b0, 2'd0, '0);
    #1;
    n_chk++;
    if (req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL b2b_rd_ready got %b want 001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    n_chk++;
    if (rsp_valid !== 3'b001 || rsp_data !== 64'd7) begin
      n_err++;
      $display("FAIL b2b_rsp got valid=%b data=%h want 001 7", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_wrap();
    issue(1, 1'b0, 2'd2, '0);
    #1;
    n_chk++;
    if (req_ready !== 3'b010) begin
      n_err++;
      $display("FAIL wrap_first got %b want 010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    issue(0, 1'b0, 2'd0, '0);
    set_ch(1, 1'b0, 2'd1, '0);
    #1;
    n_chk++;
    if (req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL wrap_search got %b want 001", req_ready);
    end
    @(negedge clk);
    req_valid[0] = 1'b0;
    issue(1, 1'b0, 2'd1, '0);
    #1;
    n_chk++;
    if (req_ready !== 3'b010) begin
      n_err++;
      $display("FAIL wrap_held got %b want 010", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_oob();
    issue(0, 1'b1, 2'd3, 64'd5);
    #1;
    n_chk++;
    if (req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL oob_wr_ready got %b want 001", req_ready);
    end
    @(negedge clk);
    issue(0, 1'b0, 2'd3, '0);
    #1;
    n_chk++;
    if (req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL oob_rd_ready got %b want 001", req_ready);
    end
    @(negedge clk);
    issue(0, 1'b0, 2'd2, '0);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (rsp_valid !== 3'b000 || rsp_data !== 64'd102) begin
      n_err++;
      $display("FAIL rsp_hold got valid=%b data=%h want 000 102", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_reset_mid();
    int n;
`ifdef ARR_CLEAR_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({req_ready, rsp_valid, ctrl_rvalid, busy} !== 8'b0000_0001 || rsp_data !== '0 || ctrl_rdata !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs got ready=%b rsp_valid=%b rvalid=%b busy=%b", req_ready, rsp_valid, ctrl_rvalid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      n++;
      @(negedge clk);
    end
    n_chk++;
    if (n != DEPTH) begin
      n_err++;
      $display("FAIL mid_busy_cycles got %0d want %0d", n, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) mm[a] = '0;
`else
    issue(1, 1'b0, 2'd1, '0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({req_ready, rsp_valid, ctrl_rvalid, busy} !== 8'b0 || rsp_data !== '0 || ctrl_rdata !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs got ready=%b rsp_valid=%b rvalid=%b busy=%b rsp_data=%h", req_ready, rsp_valid, ctrl_rvalid, busy, rsp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
`endif
    rq.delete();
    cq.delete();
    for (int k = 0; k < NCH; k++) set_ch(k, 1'b0, '0, '0);
    rq.push_back('{cyc + 1, 3'b001, mm[0]});
    #1;
    n_chk++;
    if (req_ready !== 3'b001) begin
      n_err++;
      $display("FAIL ptr_after_reset got %b want 001 (n=%0d)", req_ready, n);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_rr();
    test_back_to_back();
    test_wrap();
    test_oob();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_chk++;
    if (rq.size() + cq.size() != 0) begin
      n_err++;
      $display("FAIL pending got %0d entries want 0", rq.size() + cq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
